// File: rtl/calc_sequencer_if.sv
// calc_sequencer_if: req/ack evaluation channel between the calculator sequencer and its modulo-10 ALU.
interface calc_sequencer_if;
    logic       alu_req;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [1:0] alu_op;
    logic       alu_ack;
    logic [3:0] alu_res;
    modport master (output alu_req, alu_a, alu_b, alu_op, input alu_ack, alu_res);
    modport slave  (input alu_req, alu_a, alu_b, alu_op, output alu_ack, alu_res);
endinterface

// File: rtl/calc_sequencer.sv
// calc_sequencer: key-driven operand/operator entry FSM issuing evaluations to a shared ALU.
module calc_sequencer #(
    parameter int TIMEOUT = 255
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    key_vld,
    input  logic [3:0]              key_code,
    calc_sequencer_if.master        alu,
    output logic [3:0]              disp_left,
    output logic [3:0]              disp_right,
    output logic                    busy,
    output logic                    err
);
    typedef enum logic [2:0] {WAIT_A, OPR, WAIT_B, READY, EXEC, RESULT, ERR} state_t;
    localparam logic [3:0] BLANK    = 4'd11;
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
    state_t     state, state_n;
    logic [3:0] a, a_n, b, b_n, res, res_n;
    logic [1:0] op, op_n;
    logic [7:0] tmo, tmo_n;
    logic       kd, ko, ke;
    assign kd = key_vld && key_code <= 4'd9;
    assign ko = key_vld && key_code >= 4'd12;
    assign ke = key_vld && key_code == 4'd10;
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            state <= WAIT_A;
            a     <= '0;
            b     <= '0;
            res   <= '0;
            op    <= '0;
            tmo   <= '0;
        end else begin
            state <= state_n;
            a     <= a_n;
            b     <= b_n;
            res   <= res_n;
            op    <= op_n;
            tmo   <= tmo_n;
        end
    // Key events in EXEC fall through untouched, so they are dropped rather than queued.
    always_comb begin
        state_n = state;
        a_n     = a;
        b_n     = b;
        res_n   = res;
        op_n    = op;
        tmo_n   = tmo;
        case (state)
            WAIT_A:
                if (kd) begin
                    a_n     = key_code;
                    state_n = OPR;
                end
            OPR:
                if (kd) a_n = key_code;
                else if (ko) begin
                    op_n    = key_code[1:0];
                    state_n = WAIT_B;
                end
            WAIT_B:
                if (kd) begin
                    b_n     = key_code;
                    state_n = READY;
                end else if (ko) op_n = key_code[1:0];
            READY:
                if (kd) b_n = key_code;
                else if (ko) op_n = key_code[1:0];
                else if (ke) begin
                    state_n = (op == 2'd3 && b == 4'd0) ? ERR : EXEC;
                    tmo_n   = '0;
                end
            EXEC:
                if (alu.alu_ack) begin
                    res_n   = (alu.alu_res <= 4'd9) ? alu.alu_res : res;
                    state_n = (alu.alu_res <= 4'd9) ? RESULT : ERR;
                end else if (tmo == TMO_LAST) state_n = ERR;
                else tmo_n = tmo + 8'd1;
            RESULT:
                if (kd) begin
                    a_n     = key_code;
                    state_n = OPR;
                end else if (ko) begin
                    a_n     = res;
                    op_n    = key_code[1:0];
                    state_n = WAIT_B;
                end else if (ke) begin
                    // b was already checked nonzero for divide, so repeat skips the check
                    a_n     = res;
                    tmo_n   = '0;
                    state_n = EXEC;
                end
            ERR:
                if (kd) begin
                    a_n     = key_code;
                    state_n = OPR;
                end
            default: state_n = WAIT_A;
        endcase
    end
    assign alu.alu_req = state == EXEC;
    assign alu.alu_a   = a;
    assign alu.alu_b   = b;
    assign alu.alu_op  = op;
    assign busy        = state == EXEC;
    assign err         = state == ERR;
    assign disp_left   = (state == WAIT_A || state == ERR) ? BLANK : a;
    assign disp_right  = (state == READY || state == EXEC) ? b : (state == RESULT) ? res : BLANK;
endmodule

// File: tb/tb_calc_sequencer.sv
// tb_calc_sequencer: scoreboard bench; expected ALU requests are queued at entry and checked when the DUT requests.
module tb_calc_sequencer;
    typedef struct packed {
        logic [3:0] a;
        logic [3:0] b;
        logic [1:0] op;
    } req_t;
    logic       clk, reset, key_vld, busy, err;
    logic [3:0] key_code, disp_left, disp_right, last_res;
    int         n_chk = 0, n_err = 0;
    req_t       exp_q[$];
    calc_sequencer_if alu_if ();
    calc_sequencer #(.TIMEOUT(4)) dut (
        .clk(clk), .reset(reset), .key_vld(key_vld), .key_code(key_code), .alu(alu_if),
        .disp_left(disp_left), .disp_right(disp_right), .busy(busy), .err(err)
    );
    initial clk = 1'b0;
    always #5 clk = ~clk;
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask
    function automatic logic [3:0] alu_fn(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op);
        int x;
        case (op)
            2'd0: x = (int'(a) + int'(b)) % 10;
            2'd1: x = (int'(a) + 10 - int'(b)) % 10;
            2'd2: x = (int'(a) * int'(b)) % 10;
            default: x = (b == 0) ? 0 : int'(a) / int'(b);
        endcase
        return 4'(x);
    endfunction
    task automatic key(input logic [3:0] c);
        key_vld = 1'b1;
        key_code = c;
        @(posedge clk);
        #1 key_vld = 1'b0;
    endtask
    task automatic serve(input int dly, input int force_res, input bit drop_key);
        req_t e;
        int t = 0;
        while (alu_if.alu_req !== 1'b1 && t < 20) begin
            @(posedge clk);
            #1 t++;
        end
        check("req_seen", alu_if.alu_req, 1);
        check("sb_pending", exp_q.size() > 0, 1);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        check("alu_a", alu_if.alu_a, e.a);
        check("alu_b", alu_if.alu_b, e.b);
        check("alu_op", alu_if.alu_op, e.op);
        repeat (dly) begin
            @(posedge clk);
            #1 check("req_held", alu_if.alu_req, 1);
            check("a_stable", alu_if.alu_a, e.a);
        end
        last_res = (force_res >= 0) ? 4'(force_res) : alu_fn(e.a, e.b, e.op);
        alu_if.alu_ack = 1'b1;
        alu_if.alu_res = last_res;
        if (drop_key) begin
            key_vld = 1'b1;
            key_code = 4'd5;
        end
        @(posedge clk);
        #1 alu_if.alu_ack = 1'b0;
        key_vld = 1'b0;
        check("req_drop", alu_if.alu_req, 0);
    endtask
    initial begin
        int n;
        reset = 1'b0;
        key_vld = 1'b0;
        key_code = '0;
        alu_if.alu_ack = 1'b0;
        alu_if.alu_res = '0;
        #3;
        check("rst_req", alu_if.alu_req, 0);
        check("rst_a", alu_if.alu_a, 0);
        check("rst_b", alu_if.alu_b, 0);
        check("rst_op", alu_if.alu_op, 0);
        check("rst_left", disp_left, 11);
        check("rst_right", disp_right, 11);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        @(posedge clk);
        #1 reset = 1'b1;
        // basic add with one-cycle ack delay
        key(4'd10);
        key(4'd12);
        check("ign_left", disp_left, 11);
        key(4'd3);
        check("opr_left", disp_left, 3);
        check("opr_right", disp_right, 11);
        key(4'd12);
        key(4'd4);
        check("rdy_right", disp_right, 4);
        exp_q.push_back('{4'd3, 4'd4, 2'd0});
        key(4'd10);
        check("exec_busy", busy, 1);
        serve(1, -1, 1'b0);
        check("add_left", disp_left, 3);
        check("add_right", disp_right, 7);
        // chaining then repeat-last-op
        key(4'd14);
        key(4'd2);
        exp_q.push_back('{4'd7, 4'd2, 2'd2});
        key(4'd10);
        serve(0, -1, 1'b0);
        check("chain_left", disp_left, 7);
        check("chain_right", disp_right, 4);
        exp_q.push_back('{4'd4, 4'd2, 2'd2});
        key(4'd10);
        serve(0, -1, 1'b0);
        check("rep_left", disp_left, 4);
        check("rep_right", disp_right, 8);
        // divide by zero
        key(4'd8);
        key(4'd15);
        key(4'd0);
        key(4'd10);
        check("dz_req", alu_if.alu_req, 0);
        check("dz_err", err, 1);
        check("dz_left", disp_left, 11);
        check("dz_right", disp_right, 11);
        key(4'd5);
        check("dz_clr", err, 0);
        check("dz_new", disp_left, 5);
        // timeout with a silent ALU, then a late ack
        key(4'd12);
        key(4'd1);
        key(4'd10);
        check("tmo_a", alu_if.alu_a, 5);
        check("tmo_b", alu_if.alu_b, 1);
        n = 0;
        while (busy === 1'b1 && n < 10) begin
            n++;
            @(posedge clk);
            #1;
        end
        check("tmo_cycles", n, 4);
        check("tmo_err", err, 1);
        alu_if.alu_ack = 1'b1;
        alu_if.alu_res = 4'd3;
        @(posedge clk);
        #1 alu_if.alu_ack = 1'b0;
        check("late_err", err, 1);
        check("late_right", disp_right, 11);
        // drop and replace, keys during EXEC discarded
        key(4'd2);
        key(4'd12);
        key(4'd13);
        key(4'd9);
        key(4'd6);
        key(4'd11);
        check("rpl_right", disp_right, 6);
        exp_q.push_back('{4'd2, 4'd6, 2'd1});
        key(4'd10);
        key(4'd7);
        check("drop_busy", busy, 1);
        check("drop_left", disp_left, 2);
        serve(0, -1, 1'b1);
        check("drop_res_left", disp_left, 2);
        check("drop_res_right", disp_right, alu_fn(4'd2, 4'd6, 2'd1));
        check("drop_err", err, 0);
        // out-of-range ALU result
        key(4'd1);
        key(4'd12);
        key(4'd1);
        exp_q.push_back('{4'd1, 4'd1, 2'd0});
        key(4'd10);
        serve(0, 12, 1'b0);
        check("bad_res_err", err, 1);
        // async reset mid-EXEC
        key(4'd3);
        key(4'd12);
        key(4'd4);
        key(4'd10);
        check("mid_req", alu_if.alu_req, 1);
        #2 reset = 1'b0;
        #1;
        check("arst_req", alu_if.alu_req, 0);
        check("arst_busy", busy, 0);
        check("arst_a", alu_if.alu_a, 0);
        check("arst_left", disp_left, 11);
        check("arst_right", disp_right, 11);
        @(posedge clk);
        #1 reset = 1'b1;
        alu_if.alu_ack = 1'b1;
        alu_if.alu_res = 4'd7;
        @(posedge clk);
        #1 alu_if.alu_ack = 1'b0;
        check("ack_ign_right", disp_right, 11);
        check("ack_ign_req", alu_if.alu_req, 0);
        key(4'd9);
        check("post_left", disp_left, 9);
        check("sb_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
